mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - Memory-stage bus bridge between the pipelined core's data port (Addr_out/Data_out/mem_w/DMType, Data_in, MIO_ready)
//   and the word-wide data RAM / MMIO bus. Generates byte strobes, runs a req/ack handshake with timeout,
//   sign/zero-extends loads, flags misaligned accesses, and holds the core via cpu_ready until each access completes.
// PARAMETERS
// - TIMEOUT   16  max cycles bus_req may wait for bus_ack/bus_err before the access aborts (>=2)
// - ERR_RDATA 0   32-bit load data returned on error, timeout or misalignment
// PORTS
// - clk         in   1   core clock; all state on posedge
// - rst         in   1   asynchronous, active-high reset
// - cpu_addr    in   32  byte address from the MEM stage (ALU result)
// - cpu_wdata   in   32  store data, unaligned (value in low bits)
// - cpu_we      in   1   store request
// - cpu_re      in   1   load request (WDSel == FromMEM in MEM stage)
// - cpu_dmtype  in   3   access size/sign, DMType codes from ctrl_encode_def.v
// - cpu_rdata   out  32  extended load data; valid while cpu_ready=1
// - cpu_ready   out  1   one-cycle completion pulse; drives core MIO_ready
// - cpu_stall   out  1   (cpu_we|cpu_re) & ~cpu_ready; freezes PC, IF/ID, ID/EX, EX/MEM
// - cpu_fault   out  2   with cpu_ready: 00 ok, 01 misaligned, 10 bus error, 11 timeout
// - bus_req     out  1   request valid, held until ack/err/timeout
// - bus_we      out  1   1=write
// - bus_addr    out  32  word-aligned address ({cpu_addr[31:2],2'b00})
// - bus_wstrb   out  4   byte-lane write enables (0000 for reads)
// - bus_wdata   out  32  lane-replicated store data
// - bus_rdata   in   32  read word, valid with bus_ack
// - bus_ack     in   1   completion; may arrive in the first bus_req cycle
// - bus_err     in   1   slave error; takes priority over bus_ack in the same cycle
// BEHAVIOUR
// - Reset: state IDLE, all outputs 0, timeout counter 0; bus_req drops asynchronously, including mid-access.
// - DMType codes: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; other codes are treated as word.
// - FSM IDLE -> REQ -> RESP -> IDLE; MIS is entered from IDLE.
//   IDLE: when cpu_we|cpu_re, latch addr/wdata/we/dmtype; aligned -> REQ, misaligned -> MIS.
//     cpu_we&cpu_re is a write; cpu_re is ignored.
//   REQ: bus_req=1, bus outputs from latched regs and stable throughout.
//     bus_err -> RESP(fault 10); bus_ack -> RESP(fault 00, latch bus_rdata);
//     counter reaches TIMEOUT-1 with neither -> RESP(fault 11).
//   MIS: no bus activity; -> RESP(fault 01).
//   RESP: cpu_ready=1 for exactly one cycle with cpu_rdata/cpu_fault; -> IDLE.
//     The core advances on this edge; IDLE samples the next request one cycle later.
// - Latency: capture at T, bus_req T+1. A zero-wait ack at T+1 gives cpu_ready at T+2; each wait state adds 1 cycle.
// - Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Bytes are never misaligned.
// - Store lanes:
//   byte: wstrb=0001<<a[1:0], wdata={4{wdata[7:0]}}
//   half: wstrb=0011<<{a[1],0}, wdata={2{wdata[15:0]}}
//   word: wstrb=1111
// - Load: select lane by latched a[1:0] and sign- or zero-extend per dmtype. Fault -> ERR_RDATA.
//   cpu_rdata holds its last value outside RESP.
// - Timeout counter: $clog2(TIMEOUT) bits; cleared on entry to REQ; saturates, never wraps.
// - A bus_ack/bus_err arriving outside REQ is ignored.
// STRUCTURE
// - DMType codes and fault codes go in ctrl_encode_def.v (`dm_*, `MAF_*). FSM state encoding is local localparams.
// - One combinational sub-module, mem_lane_align: strobe/wdata steering, load extraction/extension, misalign detect.
//   FSM, counter and registers stay in mem_access_unit.
// TESTING
// - SW addr 0x100, data 0xDEADBEEF, ack in 1st req cycle -> bus_wstrb=1111, addr 0x100, cpu_ready exactly 2 cycles after request.
// - SB addr 0x203, data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5; LB/LBU same addr with rdata 0x80xxxxxx -> 0xFFFFFF80 / 0x00000080.
// - LH addr 0x102, bus_rdata 0x8001_1234, ack after 3 waits -> cpu_rdata 0xFFFF8001, cpu_ready at T+5, cpu_stall high T..T+4.
// - LW addr 0x102 -> no bus_req, cpu_fault=01, cpu_rdata=0, ready 2 cycles after request.
// - LW, never ack (TIMEOUT=16) -> bus_req high 16 cycles then low, fault=11; bus_err+ack same cycle -> fault=10.
// - rst pulsed during REQ -> bus_req low the same cycle; after release, a new SW completes normally with no stale ready.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory-stage bus bridge: access sizes, fault codes, FSM states.
package mem_access_unit_pkg;

  localparam logic [2:0] dm_word  = 3'b000;
  localparam logic [2:0] dm_half  = 3'b001;
  localparam logic [2:0] dm_halfu = 3'b010;
  localparam logic [2:0] dm_byte  = 3'b011;
  localparam logic [2:0] dm_byteu = 3'b100;

  localparam logic [1:0] maf_ok         = 2'b00;
  localparam logic [1:0] maf_misaligned = 2'b01;
  localparam logic [1:0] maf_bus_err    = 2'b10;
  localparam logic [1:0] maf_timeout    = 2'b11;

  typedef enum logic [1:0] {st_idle, st_req, st_mis, st_resp} state_t;

  // Unused codes fall back to a full-word access.
  function automatic logic [2:0] norm_dmtype(input logic [2:0] dm);
    if (dm > dm_byteu) return dm_word;
    return dm;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data bus between the bridge (master) and RAM / MMIO (slave).
// Handshake: bus_req is held with stable addr/we/wstrb/wdata until the slave
// returns bus_ack or bus_err for one cycle; bus_err wins if both are set.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_rdata, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_rdata, bus_ack, bus_err
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for stores, lane extraction plus sign/zero extension for
// loads, and misalignment detection. Purely combinational.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  dmtype,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wlanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [2:0]  dm;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign dm = norm_dmtype(dmtype);

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb      = 4'b1111;
    wlanes     = wdata;
    rdata_ext  = rdata;
    misaligned = (addr != 2'b00);
    case (dm)
      dm_byte, dm_byteu: begin
        wstrb      = 4'b0001 << addr;
        wlanes     = {4{wdata[7:0]}};
        rdata_ext  = (dm == dm_byte) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        misaligned = 1'b0;
      end
      dm_half, dm_halfu: begin
        wstrb      = 4'b0011 << {addr[1], 1'b0};
        wlanes     = {2{wdata[15:0]}};
        rdata_ext  = (dm == dm_half) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        misaligned = addr[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bridge: captures a core load/store, runs one bus transaction
// with timeout, and returns a one-cycle cpu_ready pulse with data and fault code.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  input  logic               cpu_we,
  input  logic               cpu_re,
  input  logic [2:0]         cpu_dmtype,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_stall,
  output logic [1:0]         cpu_fault,
  output state_t             dbg_state,
  mem_access_unit_if.master  bus
);
  localparam int cw = $clog2(TIMEOUT);
  localparam logic [cw-1:0] cnt_last = cw'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          we_q;
  logic [2:0]    dm_q;
  logic [1:0]    fault_q;
  logic [cw-1:0] cnt;

  logic          idle, in_req;
  logic [1:0]    al_addr;
  logic [2:0]    al_dm;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wlanes, al_rdata;
  logic          al_mis;

  assign idle   = (state == st_idle);
  assign in_req = (state == st_req);

  // In IDLE the aligner judges the incoming request; afterwards it serves the latched one.
  assign al_addr = idle ? cpu_addr[1:0] : addr_q[1:0];
  assign al_dm   = idle ? cpu_dmtype    : dm_q;

  mem_lane_align u_align (
    .addr       (al_addr),
    .dmtype     (al_dm),
    .wdata      (wdata_q),
    .rdata      (bus.bus_rdata),
    .wstrb      (al_wstrb),
    .wlanes     (al_wlanes),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= st_idle;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      st_idle: if (cpu_we || cpu_re) state_n = al_mis ? st_mis : st_req;
      st_req:  if (bus.bus_err || bus.bus_ack || cnt == cnt_last) state_n = st_resp;
      st_mis:  state_n = st_resp;
      st_resp: state_n = st_idle;
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      dm_q    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      fault_q <= maf_ok;
    end else begin
      case (state)
        st_idle: if (cpu_we || cpu_re) begin
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          we_q    <= cpu_we;
          dm_q    <= cpu_dmtype;
          cnt     <= '0;
        end
        st_req: begin
          if (bus.bus_err) begin
            fault_q <= maf_bus_err;
            rdata_q <= ERR_RDATA;
          end else if (bus.bus_ack) begin
            fault_q <= maf_ok;
            rdata_q <= al_rdata;
          end else if (cnt == cnt_last) begin
            fault_q <= maf_timeout;
            rdata_q <= ERR_RDATA;
          end
          if (cnt != cnt_last) cnt <= cnt + 1'b1;
        end
        st_mis: begin
          fault_q <= maf_misaligned;
          rdata_q <= ERR_RDATA;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ready = (state == st_resp);
  assign cpu_fault = cpu_ready ? fault_q : maf_ok;
  assign cpu_rdata = rdata_q;
  assign cpu_stall = (cpu_we || cpu_re) && !cpu_ready;
  assign dbg_state = state;

  // Bus outputs are quiet outside REQ so reset and idle present an all-zero bus.
  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req && we_q;
  assign bus.bus_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.bus_wstrb = (in_req && we_q) ? al_wstrb : 4'b0000;
  assign bus.bus_wdata = in_req ? al_wlanes : 32'h0;
endmodule
